spike_event_logger: RTL and testbench

SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

---
 rtl/spike_event_logger.sv | 191 +++++++++++++++++++
 tb/tb_spike_event_logger.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_logger.sv
// -----------------------------------------------------------------------------
// spike_event_logger
//
// Timestamps the 2-bit output-layer spike pattern of an SNN and queues each
// non-empty pattern as a 16-bit event word in a first-word-fall-through FIFO.
//
//   event word = {spike_pattern[1:0], timestamp[13:0]}
//
// The 14-bit timestamp counts qualified samples (wrapping 16383 -> 0). Every
// qualified sample advances it; only samples with a non-zero pattern are
// stored, tagged with the timestamp value before the increment.
//
// Build option:
//   SPIKE_LOGGER_EDGE_DETECT_EN  defined   -> sample is a level; only a 0->1
//                                             transition is a qualified sample.
//                                undefined -> every cycle with sample=1 is a
//                                             qualified sample.
//
// Parameters:
//   DEPTH          FIFO entry count, power of two in 2..64.
//
// Ports:
//   system_clock   in   1     sole clock, rising edge
//   reset          in   1     asynchronous, active-low
//   sample         in   1     time-step strobe
//   output_spikes  in   2     spike pattern, valid with a qualified sample
//   clear          in   1     synchronous flush of FIFO, timestamp, overflow
//   event_ready    in   1     consumer accepts the head word
//   event_data     out  16    head word, 0 while the FIFO is empty
//   event_valid    out  1     FIFO non-empty
//   fifo_count     out  clog2(DEPTH)+1   stored entries
//   overflow       out  1     sticky: an event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module spike_event_logger #(
    parameter int DEPTH = 8
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     sample,
    input  logic [1:0]               output_spikes,
    input  logic                     clear,
    input  logic                     event_ready,
    output logic [15:0]              event_data,
    output logic                     event_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    // -------------------------------------------------------------------------
    // Sample qualification
    // -------------------------------------------------------------------------
    logic qualified;

`ifdef SPIKE_LOGGER_EDGE_DETECT_EN
    logic sample_prev_reg;

    // Tracks sample even during clear, so a strobe held high across a clear
    // is not counted a second time.
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            sample_prev_reg <= 1'b0;
        end else begin
            sample_prev_reg <= sample;
        end
    end

    assign qualified = sample & ~sample_prev_reg;
`else
    assign qualified = sample;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic [13:0]   ts_reg,     ts_next;
    logic          overflow_reg, overflow_next;
    logic [15:0]   head_reg,   head_next;

    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          do_push;
    logic          mem_we;
    logic [15:0]   push_word;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign pop       = ~empty & event_ready;
    assign push_req  = qualified & (output_spikes != 2'b00);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push   = push_req & (~full | pop);
    assign mem_we    = do_push & ~clear;
    assign push_word = {output_spikes, ts_reg};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        ts_next       = ts_reg;
        overflow_next = overflow_reg;
        head_next     = head_reg;

        if (clear) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            ts_next       = '0;
            overflow_next = 1'b0;
            head_next     = '0;
        end else begin
            if (qualified) begin
                ts_next = ts_reg + 14'd1;
            end
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (do_push && !pop) begin
                count_next = count_reg + CW'(1);
            end else if (!do_push && pop) begin
                count_next = count_reg - CW'(1);
            end
            if (push_req && full && !pop) begin
                overflow_next = 1'b1;
            end

            // The head register holds the entry at the new read pointer. When
            // that entry is the one being written on this edge (FIFO empty, or
            // last entry leaving while a new one arrives) it is not in the
            // array yet, so the incoming word is forwarded instead.
            if (count_next == '0) begin
                head_next = '0;
            end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = push_word;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ts_reg       <= '0;
            overflow_reg <= 1'b0;
            head_reg     <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            ts_reg       <= ts_next;
            overflow_reg <= overflow_next;
            head_reg     <= head_next;
        end
    end

    // Storage array carries no reset: stale contents are unreachable because
    // the pointers and count are reset.
    always_ff @(posedge system_clock) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign event_data  = head_reg;
    assign event_valid = ~empty;
    assign fifo_count  = count_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_spike_event_logger.sv
module tb_spike_event_logger;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          system_clock = 1'b0;
    logic          reset        = 1'b1;
    logic          sample       = 1'b0;
    logic [1:0]    output_spikes = 2'b00;
    logic          clear        = 1'b0;
    logic          event_ready  = 1'b0;
    logic [15:0]   event_data;
    logic          event_valid;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    spike_event_logger #(.DEPTH(DEPTH)) dut (
        .system_clock  (system_clock),
        .reset         (reset),
        .sample        (sample),
        .output_spikes (output_spikes),
        .clear         (clear),
        .event_ready   (event_ready),
        .event_data    (event_data),
        .event_valid   (event_valid),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: a queue of event words plus a timestamp and flag
    // ------------------------------------------------------------------
    logic [15:0] mq[$];
    int          m_ts   = 0;
    bit          m_ovf  = 1'b0;
    bit          m_prev = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_ts   = 0;
        m_ovf  = 1'b0;
        m_prev = 1'b0;
    endtask

    task automatic model_edge();
        bit q;
        bit do_pop;
        int sz;
`ifdef SPIKE_LOGGER_EDGE_DETECT_EN
        q = sample && !m_prev;
`else
        q = sample;
`endif
        m_prev = sample;
        if (clear) begin
            mq.delete();
            m_ts  = 0;
            m_ovf = 1'b0;
        end else begin
            sz     = mq.size();
            do_pop = (sz > 0) && event_ready;
            if (do_pop) void'(mq.pop_front());
            if (q && output_spikes != 2'b00) begin
                if (sz == DEPTH && !do_pop) m_ovf = 1'b1;
                else mq.push_back({output_spikes, 14'(m_ts)});
            end
            if (q) m_ts = (m_ts + 1) % 16384;
        end
    endtask

    function automatic logic [15:0] m_head();
        return (mq.size() > 0) ? mq[0] : 16'h0000;
    endfunction

    function automatic logic [CW+17:0] m_outputs();
        return {mq.size() > 0, m_head(), CW'(mq.size()), m_ovf};
    endfunction

    task automatic tick();
        @(posedge system_clock);
        model_edge();
        #1;
    endtask

    // one isolated qualified sample followed by an idle cycle
    task automatic pulse(input logic [1:0] sp, input logic rdy);
        sample = 1'b1; output_spikes = sp; event_ready = rdy;
        tick();
        sample = 1'b0; output_spikes = 2'b00;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1; sample = 1'b0; event_ready = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({event_valid, event_data, fifo_count, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got v=%0b d=%h c=%0d o=%0b, need all 0",
                     event_valid, event_data, fifo_count, overflow);
        end
        repeat (2) @(posedge system_clock);
        #1 reset = 1'b1;
        tick();
        tests_run++;
        if ({event_valid, event_data, fifo_count, overflow} !== m_outputs()) begin
            tests_failed++;
            $display("FAIL reset_release: got v=%0b d=%h c=%0d o=%0b, need idle",
                     event_valid, event_data, fifo_count, overflow);
        end
    endtask

    task automatic test_basic();
        sample = 1'b1; output_spikes = 2'b01; event_ready = 1'b1;
        tick();
        tests_run++;
        if ({event_valid, event_data} !== {1'b1, 16'h4000}) begin
            tests_failed++;
            $display("FAIL basic_word0: got v=%0b d=%h, need v=1 d=4000", event_valid, event_data);
        end
        sample = 1'b0; tick();
        sample = 1'b1; output_spikes = 2'b00; tick();
        sample = 1'b0; tick();
        tests_run++;
        if (event_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_zero_spikes: got v=%0b, need 0", event_valid);
        end
        sample = 1'b1; output_spikes = 2'b10; tick();
        tests_run++;
        if ({event_valid, event_data} !== {1'b1, 16'h8002}) begin
            tests_failed++;
            $display("FAIL basic_word1: got v=%0b d=%h, need v=1 d=8002", event_valid, event_data);
        end
        sample = 1'b0; output_spikes = 2'b00; tick();
        tests_run++;
        if ({event_valid, event_data, fifo_count} !== {1'b0, 16'h0000, CW'(0)}) begin
            tests_failed++;
            $display("FAIL basic_drained: got v=%0b d=%h c=%0d, need 0 0000 0",
                     event_valid, event_data, fifo_count);
        end
        // empty FIFO with ready held: nothing pops
        tick();
        tests_run++;
        if (fifo_count !== CW'(0)) begin
            tests_failed++;
            $display("FAIL empty_ready: got c=%0d, need 0", fifo_count);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < DEPTH + 1; i++) pulse(2'b11, 1'b0);
        tests_run++;
        if ({fifo_count, overflow, event_data} !== {CW'(DEPTH), 1'b1, 16'hC000}) begin
            tests_failed++;
            $display("FAIL overflow_full: got c=%0d o=%0b d=%h, need c=%0d o=1 d=c000",
                     fifo_count, overflow, event_data, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests_run++;
            if (event_data !== 16'hC000 + 16'(i)) begin
                tests_failed++;
                $display("FAIL overflow_drain%0d: got d=%h, need %h", i, event_data, 16'hC000 + 16'(i));
            end
            event_ready = 1'b1; tick();
        end
        event_ready = 1'b0; tick();
        tests_run++;
        if ({event_valid, overflow} !== 2'b01) begin
            tests_failed++;
            $display("FAIL overflow_sticky: got v=%0b o=%0b, need v=0 o=1", event_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_clear();
        for (int i = 0; i < DEPTH; i++) pulse(2'b11, 1'b0);
        sample = 1'b1; output_spikes = 2'b01; event_ready = 1'b1;
        tick();
        sample = 1'b0; output_spikes = 2'b00; event_ready = 1'b0;
        tests_run++;
        if ({fifo_count, overflow, event_data} !== {CW'(DEPTH), 1'b0, 16'hC001}) begin
            tests_failed++;
            $display("FAIL fullpp: got c=%0d o=%0b d=%h, need c=%0d o=0 d=c001",
                     fifo_count, overflow, event_data, DEPTH);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            event_ready = 1'b1; tick();
        end
        event_ready = 1'b0;
        tests_run++;
        if ({fifo_count, event_data} !== {CW'(1), 16'h4000 | 16'(DEPTH)}) begin
            tests_failed++;
            $display("FAIL fullpp_tail: got c=%0d d=%h, need c=1 d=%h",
                     fifo_count, event_data, 16'h4000 | 16'(DEPTH));
        end
    endtask

    task automatic test_wrap();
        do_clear();
        event_ready = 1'b1;
`ifdef SPIKE_LOGGER_EDGE_DETECT_EN
        for (int i = 0; i < 16384; i++) pulse(2'b00, 1'b1);
`else
        sample = 1'b1; output_spikes = 2'b00;
        repeat (16384) tick();
        sample = 1'b0; tick();
`endif
        event_ready = 1'b0;
        sample = 1'b1; output_spikes = 2'b10; tick();
        sample = 1'b0; output_spikes = 2'b00;
        tests_run++;
        if ({fifo_count, event_data} !== {CW'(1), 16'h8000}) begin
            tests_failed++;
            $display("FAIL ts_wrap: got c=%0d d=%h, need c=1 d=8000", fifo_count, event_data);
        end
    endtask

    task automatic test_held();
        int n;
`ifdef SPIKE_LOGGER_EDGE_DETECT_EN
        n = 1;
`else
        n = 5;
`endif
        do_clear();
        sample = 1'b1; output_spikes = 2'b01;
        repeat (5) tick();
        sample = 1'b0; output_spikes = 2'b00; tick();
        tests_run++;
        if (fifo_count !== CW'(n)) begin
            tests_failed++;
            $display("FAIL held_count: got c=%0d, need %0d", fifo_count, n);
        end
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (event_data !== 16'h4000 + 16'(i)) begin
                tests_failed++;
                $display("FAIL held_word%0d: got d=%h, need %h", i, event_data, 16'h4000 + 16'(i));
            end
            event_ready = 1'b1; tick();
        end
        event_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < DEPTH + 1; i++) pulse(2'b10, 1'b0);
        event_ready = 1'b1;
        repeat (DEPTH - 3) tick();
        event_ready = 1'b0;
        tests_run++;
        if ({fifo_count, overflow} !== {CW'(3), 1'b1}) begin
            tests_failed++;
            $display("FAIL clear_setup: got c=%0d o=%0b, need c=3 o=1", fifo_count, overflow);
        end
        clear = 1'b1; sample = 1'b1; output_spikes = 2'b11; event_ready = 1'b1;
        tick();
        clear = 1'b0; sample = 1'b0; output_spikes = 2'b00; event_ready = 1'b0;
        tests_run++;
        if ({event_valid, event_data, fifo_count, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL clear_flush: got v=%0b d=%h c=%0d o=%0b, need all 0",
                     event_valid, event_data, fifo_count, overflow);
        end
        tick();
        sample = 1'b1; output_spikes = 2'b01; tick();
        sample = 1'b0; output_spikes = 2'b00;
        tests_run++;
        if (event_data !== 16'h4000) begin
            tests_failed++;
            $display("FAIL clear_ts: got d=%h, need 4000", event_data);
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        for (int i = 0; i < 3; i++) pulse(2'b01, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({event_valid, event_data, fifo_count, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: got v=%0b d=%h c=%0d o=%0b, need all 0",
                     event_valid, event_data, fifo_count, overflow);
        end
        @(posedge system_clock);
        #1 reset = 1'b1;
        sample = 1'b1; output_spikes = 2'b11; tick();
        sample = 1'b0; output_spikes = 2'b00;
        tests_run++;
        if ({fifo_count, event_data} !== {CW'(1), 16'hC000}) begin
            tests_failed++;
            $display("FAIL reset_mid_ts: got c=%0d d=%h, need c=1 d=c000", fifo_count, event_data);
        end
    endtask

    task automatic test_random();
        int ready_pct;
        do_clear();
        for (int i = 0; i < 2400; i++) begin
            ready_pct     = ((i / 150) % 2 == 0) ? 20 : 85;
            sample        = ($urandom_range(0, 99) < 60);
            output_spikes = 2'($urandom_range(0, 3));
            event_ready   = ($urandom_range(0, 99) < ready_pct);
            clear         = ($urandom_range(0, 299) == 0);
            tick();
            tests_run++;
            if ({event_valid, event_data, fifo_count, overflow} !== m_outputs()) begin
                tests_failed++;
                $display("FAIL random_cyc%0d: got v=%0b d=%h c=%0d o=%0b, need v=%0b d=%h c=%0d o=%0b",
                         i, event_valid, event_data, fifo_count, overflow,
                         mq.size() > 0, m_head(), mq.size(), m_ovf);
            end
        end
        sample = 1'b0; clear = 1'b0; event_ready = 1'b0; output_spikes = 2'b00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_held();
        test_clear();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
